// File: rtl/vga_pkg.sv
// Shared definitions for the VGA video-memory arbiter and its CPU-side users.
package vga_pkg;

    localparam int VRAM_ADDR_W    = 24;
    localparam int VRAM_DATA_W    = 8;
    localparam int TEXT_ATTR_BASE = 2400;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_WAIT  = 2'd1,
        ST_RD_ISSUE = 2'd2,
        ST_RD_DATA  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/vga_wr_fifo.sv
// Small synchronous FIFO that buffers CPU {address, data} writes until the
// display releases the bus during blanking.
module vga_wr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        full    = (count_q == (PTR_W+1)'(DEPTH));
        empty   = (count_q == '0);
        rdata   = mem_q[rptr_q];
        do_push = push && !full;
        do_pop  = pop && !empty;

        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end

        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible once the count covers them.
    always_ff @(posedge clk_in) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: display owns the bus while visible, buffered CPU
// writes drain and CPU reads are serviced only during blanking.
//
//   state        | meaning
//   ST_IDLE      | accepting CPU requests (writes go straight to the FIFO)
//   ST_RD_WAIT   | read pending, waiting for buffered writes to drain
//   ST_RD_ISSUE  | read address on the bus once blanking allows it
//   ST_RD_DATA   | capture VRAM data, pulse cpu_ack
module vga_vram_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W     = VRAM_ADDR_W,
    parameter int DATA_W     = VRAM_DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              active,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              wbuf_full,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e                state_q, state_d;
    logic                      ack_q, ack_d;
    logic [DATA_W-1:0]         rdata_q, rdata_d;
    logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [ADDR_W+DATA_W-1:0]  fifo_head;

    vga_wr_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .wdata  ({cpu_addr, cpu_wdata}),
        .rdata  (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        fifo_push = (state_q == ST_IDLE) && cpu_req && cpu_we && !fifo_full && !ack_q;
        fifo_pop  = active && !fifo_empty;

        state_d = state_q;
        ack_d   = 1'b0;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (fifo_push) begin
                    ack_d = 1'b1;
                end else if (cpu_req && !cpu_we && !ack_q) begin
                    state_d = ST_RD_WAIT;
                end
            end
            // Reads must observe every write buffered ahead of them.
            ST_RD_WAIT: begin
                if (fifo_empty) begin
                    state_d = ST_RD_ISSUE;
                end
            end
            ST_RD_ISSUE: begin
                if (active) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                rdata_d = mem_rdata;
                ack_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = disp_addr;
        mem_we    = 1'b0;
        mem_wdata = fifo_head[DATA_W-1:0];
        if (active) begin
            if (!fifo_empty) begin
                mem_addr = fifo_head[ADDR_W+DATA_W-1:DATA_W];
                mem_we   = rst_n;
            end else if (state_q == ST_RD_ISSUE) begin
                mem_addr = cpu_addr;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    assign disp_data = mem_rdata;
    assign cpu_ack   = ack_q;
    assign cpu_rdata = rdata_q;
    assign wbuf_full = fifo_full;
    assign busy      = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Self-checking bench for vga_vram_arbiter: directed corner cases, a vector
// table and randomized traffic against a shadow-memory / write-order model.
module tb_vga_vram_arbiter;

    localparam int AW = 24;
    localparam int DW = 8;

    logic          clk_in = 1'b0;
    logic          rst_n;
    logic          active;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          wbuf_full;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0]    vram   [256] = '{default: '0};
    logic [DW-1:0]    shadow [256];
    logic [AW+DW-1:0] exp_wr_q [$];

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
        logic       act0;
        int         blank_after;
        logic [7:0] exp_rdata;
        int         exp_lat;
    } vec_t;

    vec_t          vecs [8];
    logic [DW-1:0] rd;
    int            lat;

    always #5 clk_in = ~clk_in;

    vga_vram_arbiter dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .active    (active),
        .disp_addr (disp_addr),
        .disp_data (disp_data),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .wbuf_full (wbuf_full),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always @(posedge clk_in) begin
        if (mem_we) vram[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= vram[mem_addr[7:0]];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Bus ownership and write ordering, checked every cycle.
    always @(negedge clk_in) begin
        #1;
        if (rst_n) begin
            check("disp_data", 32'(disp_data), 32'(mem_rdata));
            if (!active) begin
                check("visible_addr", 32'(mem_addr), 32'(disp_addr));
                check("visible_we", 32'(mem_we), 32'd0);
            end
            if (mem_we) begin
                check("write_expected", 32'(exp_wr_q.size() != 0), 32'd1);
                if (exp_wr_q.size() != 0) begin
                    check("write_order", 32'({mem_addr, mem_wdata}), 32'(exp_wr_q[0]));
                    void'(exp_wr_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic cpu_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input int blank_after, input bit rnd,
                           output logic [DW-1:0] rdata, output int latency);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = data;
        if (we) begin
            exp_wr_q.push_back({addr, data});
            shadow[addr[7:0]] = data;
        end
        latency = 0;
        rdata   = '0;
        for (int i = 1; i <= 200; i++) begin
            if (rnd) begin
                disp_addr = AW'($urandom);
                if ($urandom_range(0, 3) == 0) active = ~active;
            end
            tick();
            if (cpu_ack) begin
                latency = i;
                rdata   = cpu_rdata;
                break;
            end
            if (i == blank_after) active = 1'b1;
        end
        check("ack_seen", 32'(latency != 0), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = '0;
        vecs[0] = '{1'b1, 8'h40, 8'h11, 1'b1, 0, 8'h00, 1};
        vecs[1] = '{1'b0, 8'h40, 8'h00, 1'b1, 0, 8'h11, 4};
        vecs[2] = '{1'b1, 8'h41, 8'h22, 1'b0, 0, 8'h00, 1};
        vecs[3] = '{1'b1, 8'h42, 8'h33, 1'b0, 0, 8'h00, 1};
        vecs[4] = '{1'b0, 8'h41, 8'h00, 1'b0, 5, 8'h22, 10};
        vecs[5] = '{1'b0, 8'h42, 8'h00, 1'b1, 0, 8'h33, 4};
        vecs[6] = '{1'b1, 8'h40, 8'h44, 1'b1, 0, 8'h00, 1};
        vecs[7] = '{1'b0, 8'h40, 8'h00, 1'b0, 3, 8'h44, 5};

        rst_n = 1'b0; active = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_wdata = '0; disp_addr = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("rst_ack", 32'(cpu_ack), 32'd0);
        check("rst_rdata", 32'(cpu_rdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(wbuf_full), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);

        // Reset while draining three buffered writes.
        for (int k = 0; k < 3; k++) cpu_txn(1'b1, AW'(8'hE0 + k), DW'(8'hC0 + k), 0, 0, rd, lat);
        cpu_req = 1'b0;
        tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        active = 1'b1;
        tick();
        rst_n = 1'b0;
        exp_wr_q.delete();
        #1;
        check("midrst_ack", 32'(cpu_ack), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_we", 32'(mem_we), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("postrst_busy", 32'(busy), 32'd0);

        // Write while visible, drained on the first blanking cycle.
        active = 1'b0; disp_addr = 24'h000777;
        cpu_txn(1'b1, 24'h000010, 8'hA5, 0, 0, rd, lat);
        check("vis_wr_lat", 32'(lat), 32'd1);
        check("vis_wr_we", 32'(mem_we), 32'd0);
        cpu_req = 1'b0;
        tick();
        check("vis_wr_ack_pulse", 32'(cpu_ack), 32'd0);
        tick(); tick();
        active = 1'b1;
        #1;
        check("drain_we", 32'(mem_we), 32'd1);
        check("drain_addr", 32'(mem_addr), 32'h10);
        check("drain_wdata", 32'(mem_wdata), 32'hA5);
        tick();
        check("drain_we_once", 32'(mem_we), 32'd0);

        // Fill the FIFO while visible; fifth write waits for the first pop.
        active = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cpu_txn(1'b1, AW'(8'h60 + k), DW'(8'hB0 + k), 0, 0, rd, lat);
            check("fill_lat", 32'(lat), (k == 0) ? 32'd1 : 32'd2);
        end
        check("full_flag", 32'(wbuf_full), 32'd1);
        cpu_txn(1'b1, 24'h000064, 8'hB4, 8, 0, rd, lat);
        check("full_wr_lat", 32'(lat), 32'd10);
        cpu_req = 1'b0;
        repeat (6) tick();
        check("full_drained", 32'(exp_wr_q.size()), 32'd0);
        check("full_busy", 32'(busy), 32'd0);

        // Read after write in blanking.
        active = 1'b1;
        cpu_txn(1'b1, 24'h000020, 8'h3C, 0, 0, rd, lat);
        cpu_req = 1'b0;
        tick();
        cpu_txn(1'b0, 24'h000020, 8'h00, 0, 0, rd, lat);
        check("raw_rdata", 32'(rd), 32'h3C);
        check("raw_lat", 32'(lat), 32'd4);
        cpu_req = 1'b0;
        tick();
        check("raw_ack_pulse", 32'(cpu_ack), 32'd0);

        // Read requested while visible.
        cpu_txn(1'b1, 24'h000030, 8'h5A, 0, 0, rd, lat);
        cpu_req = 1'b0;
        tick();
        active = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h000030;
        for (int i = 0; i < 6; i++) begin
            disp_addr = AW'($urandom);
            tick();
            check("vis_rd_no_ack", 32'(cpu_ack), 32'd0);
        end
        active = 1'b1; disp_addr = 24'h000123;
        #1;
        check("vis_rd_issue_addr", 32'(mem_addr), 32'h30);
        check("vis_rd_issue_we", 32'(mem_we), 32'd0);
        tick();
        check("vis_rd_one_cycle", 32'(mem_addr), 32'h123);
        check("vis_rd_early_ack", 32'(cpu_ack), 32'd0);
        tick();
        check("vis_rd_ack", 32'(cpu_ack), 32'd1);
        check("vis_rd_data", 32'(cpu_rdata), 32'h5A);
        cpu_req = 1'b0;
        tick();

        // Visible region starts exactly on the issue cycle.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 24'h000030; disp_addr = 24'h001234;
        tick(); tick();
        check("edge_issue_addr", 32'(mem_addr), 32'h30);
        active = 1'b0;
        #1;
        check("edge_disp_owns", 32'(mem_addr), 32'h1234);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("edge_held", 32'(cpu_ack), 32'd0);
        end
        active = 1'b1;
        tick(); tick();
        check("edge_ack", 32'(cpu_ack), 32'd1);
        check("edge_data", 32'(cpu_rdata), 32'h5A);
        cpu_req = 1'b0;
        tick();

        for (int v = 0; v < 8; v++) begin
            active = vecs[v].act0;
            cpu_txn(vecs[v].we, {16'h0, vecs[v].addr}, vecs[v].data, vecs[v].blank_after, 0, rd, lat);
            check($sformatf("vec%0d_lat", v), 32'(lat), 32'(vecs[v].exp_lat));
            if (!vecs[v].we) check($sformatf("vec%0d_rdata", v), 32'(rd), 32'(vecs[v].exp_rdata));
            cpu_req = 1'b0;
            tick();
        end

        // Random traffic: reads must return the last value written in program order.
        for (int n = 0; n < 60; n++) begin
            logic          we;
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            logic [DW-1:0] exp_rd;
            we = 1'($urandom_range(0, 1));
            a  = AW'(8'h50 + $urandom_range(0, 15));
            d  = DW'($urandom);
            exp_rd = shadow[a[7:0]];
            cpu_txn(we, a, d, 0, 1, rd, lat);
            if (!we) check("rand_rdata", 32'(rd), 32'(exp_rd));
            cpu_req = 1'b0;
            disp_addr = AW'($urandom);
            tick();
        end

        active = 1'b1; cpu_req = 1'b0;
        repeat (10) tick();
        check("final_drained", 32'(exp_wr_q.size()), 32'd0);
        check("final_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
